// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and the decode stage:
//   - lsu_state_t : transaction FSM states
//   - F3_*        : func3 width/sign encodings for loads and stores
//   - STRB_*      : base byte-strobe patterns, shifted into lane position
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_REQ       = 2'b01,
        S_WAIT_RESP = 2'b10,
        S_RESP      = 2'b11
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store unit.
// Ports:
//   i_func3       width/sign selector
//   i_is_store    1 = store (unsigned widths are illegal for stores)
//   i_addr_lo     byte offset within the word
//   i_wdata       right-justified store data
//   i_rdata       raw word returned by memory
//   o_wstrb       byte enables for the addressed lanes
//   o_wdata       store data replicated onto every lane
//   o_rdata       selected lane, sign- or zero-extended
//   o_misaligned  halfword/word access not naturally aligned
//   o_illegal     func3 encoding not valid for the operation
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword out of the returned word
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            2'b11:   w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Strobes, lane-replicated store data and legality per width
    always_comb begin
        o_wstrb      = 4'b0000;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_func3)
            F3_B, F3_BU: begin
                o_wstrb   = STRB_B << i_addr_lo;
                o_wdata   = {4{i_wdata[7:0]}};
                o_illegal = i_is_store && (i_func3 == F3_BU);
            end
            F3_H, F3_HU: begin
                o_wstrb      = STRB_H << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
                o_illegal    = i_is_store && (i_func3 == F3_HU);
            end
            F3_W: begin
                o_wstrb      = STRB_W;
                o_wdata      = i_wdata;
                o_misaligned = (i_addr_lo != 2'b00);
            end
            default: begin
                o_wstrb   = 4'b0000;
                o_illegal = 1'b1;
            end
        endcase
    end

    // Load data extension
    always_comb begin
        o_rdata = 32'h0000_0000;
        case (i_func3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'h00_0000, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'h0000, w_half};
            F3_W:    o_rdata = i_rdata;
            default: o_rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store engine between execute and data memory.
// Accepts one operation in IDLE, issues a req/gnt handshake, waits for
// rvalid on loads (with optional timeout) and reports via a one-cycle done.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid            execute presents an operation (taken when ready)
//   mem_read, mem_write  operation type from decode
//   func3, addr, wdata   width/sign, byte address, right-justified data
//   ready                high only while idle
//   done, err            completion pulse and its error flag
//   rdata                extended load data, held until the next load
//   dmem_req/we/addr/wstrb/wdata   memory request side
//   dmem_gnt, dmem_rvalid, dmem_rdata  memory response side
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [CNT_W:0] TIMEOUT_L  = (CNT_W+1)'(TIMEOUT_CYCLES);
    localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 32'sd0);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    logic [2:0]        r_func3;
    logic [1:0]        r_addr_lo;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W:0]    w_cnt_inc;

    logic              r_ready;
    logic              r_done;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [31:0]       r_dmem_addr;
    logic [3:0]        r_dmem_wstrb;
    logic [31:0]       r_dmem_wdata;

    logic              w_idle;
    logic              w_accept;
    logic              w_bad;
    logic              w_timeout;
    logic              w_ready_nxt;
    logic              w_done_nxt;
    logic              w_req_nxt;
    logic              w_err_nxt;
    logic              w_rdata_cap;

    logic [2:0]        w_al_func3;
    logic [1:0]        w_al_addr_lo;
    logic              w_al_is_store;
    logic [3:0]        w_al_wstrb;
    logic [31:0]       w_al_wdata;
    logic [31:0]       w_al_rdata;
    logic              w_al_misaligned;
    logic              w_al_illegal;

    assign w_idle = (r_state == S_IDLE);
    // Both read and write set is still taken, so it can be answered with err;
    // neither set is simply not a memory operation.
    assign w_accept  = req_valid && w_idle && (mem_read || mem_write);
    assign w_bad     = w_al_illegal || w_al_misaligned || (mem_read && mem_write);
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_timeout = TIMEOUT_EN && (w_cnt_inc == TIMEOUT_L);

    // Lane logic sees the live request while idle and the latched one later
    always_comb begin
        if (w_idle) begin
            w_al_func3    = func3;
            w_al_addr_lo  = addr[1:0];
            w_al_is_store = mem_write;
        end else begin
            w_al_func3    = r_func3;
            w_al_addr_lo  = r_addr_lo;
            w_al_is_store = r_dmem_we;
        end
    end

    lsu_align u_align (
        .i_func3      (w_al_func3),
        .i_is_store   (w_al_is_store),
        .i_addr_lo    (w_al_addr_lo),
        .i_wdata      (wdata),
        .i_rdata      (dmem_rdata),
        .o_wstrb      (w_al_wstrb),
        .o_wdata      (w_al_wdata),
        .o_rdata      (w_al_rdata),
        .o_misaligned (w_al_misaligned),
        .o_illegal    (w_al_illegal)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_bad ? S_RESP : S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    w_state_nxt = r_dmem_we ? S_RESP : S_WAIT_RESP;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT_RESP: begin
                if (dmem_rvalid || w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output logic, decoded from the next state so outputs are registered
    always_comb begin
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_req_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        case (w_state_nxt)
            S_IDLE:      w_ready_nxt = 1'b1;
            S_REQ:       w_req_nxt   = 1'b1;
            S_WAIT_RESP: w_req_nxt   = 1'b0;
            S_RESP:      w_done_nxt  = 1'b1;
            default:     w_ready_nxt = 1'b0;
        endcase
        // err is only meaningful alongside done; a store grant is never an error
        if (w_state_nxt == S_RESP) begin
            case (r_state)
                S_IDLE:      w_err_nxt = w_bad;
                S_WAIT_RESP: w_err_nxt = !dmem_rvalid;
                default:     w_err_nxt = 1'b0;
            endcase
        end else begin
            w_err_nxt = 1'b0;
        end
        if ((r_state == S_WAIT_RESP) && dmem_rvalid) begin
            w_rdata_cap = 1'b1;
        end else begin
            w_rdata_cap = 1'b0;
        end
    end

    // Registered handshake/status outputs and captured load data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_dmem_req <= 1'b0;
            r_rdata    <= 32'h0000_0000;
        end else begin
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_dmem_req <= w_req_nxt;
            if (w_rdata_cap) begin
                r_rdata <= w_al_rdata;
            end
        end
    end

    // Request latch: memory-side fields stay frozen from accept until grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_func3      <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 32'h0000_0000;
            r_dmem_wstrb <= 4'b0000;
            r_dmem_wdata <= 32'h0000_0000;
        end else if (w_accept) begin
            r_func3      <= func3;
            r_addr_lo    <= addr[1:0];
            r_dmem_we    <= mem_write;
            r_dmem_addr  <= {addr[31:2], 2'b00};
            r_dmem_wstrb <= w_al_wstrb;
            r_dmem_wdata <= w_al_wdata;
        end
    end

    // Response timeout counter: cleared on load grant, counts idle WAIT_RESP cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == S_REQ) && dmem_gnt) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == S_WAIT_RESP) && !dmem_rvalid) begin
            r_cnt <= w_cnt_inc[CNT_W-1:0];
        end
    end

    assign ready      = r_ready;
    assign done       = r_done;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wstrb = r_dmem_wstrb;
    assign dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed, table-driven bench for load_store_unit (TIMEOUT_CYCLES = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .func3       (func3),
        .addr        (addr),
        .wdata       (wdata),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;    // REQ cycles without grant before granting
        logic        give_rv;    // return rvalid the cycle after grant
        logic [31:0] mem_word;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        int          exp_req;    // cycles dmem_req is seen high
        int          exp_lat;    // cycles from accept to done
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'b0, ready},      32'd1);
        check({tag, "_done"},  {31'b0, done},       32'd0);
        check({tag, "_err"},   {31'b0, err},        32'd0);
        check({tag, "_rdata"}, rdata,               32'h0);
        check({tag, "_req"},   {31'b0, dmem_req},   32'd0);
        check({tag, "_we"},    {31'b0, dmem_we},    32'd0);
        check({tag, "_addr"},  dmem_addr,           32'h0);
        check({tag, "_strb"},  {28'b0, dmem_wstrb}, 32'h0);
        check({tag, "_wdata"}, dmem_wdata,          32'h0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   req_cyc;
        int   lat;
        logic seen;
        logic gnt_prev;
        @(negedge clk);
        check($sformatf("v%0d_ready_before", idx), {31'b0, ready}, 32'd1);
        req_valid = 1'b1;
        mem_read  = v.rd;
        mem_write = v.wr;
        func3     = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        seen = 1'b0; gnt_prev = 1'b0; lat = 0; req_cyc = 0;
        for (int c = 1; (c <= 40) && !seen; c++) begin
            @(negedge clk);
            req_valid   = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_gnt    = 1'b0;
            if (gnt_prev && v.give_rv) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.mem_word;
            end
            gnt_prev = 1'b0;
            if (dmem_req) begin
                req_cyc++;
                check($sformatf("v%0d_addr", idx), dmem_addr, v.exp_addr);
                check($sformatf("v%0d_we", idx), {31'b0, dmem_we}, {31'b0, v.wr});
                if (v.wr) begin
                    check($sformatf("v%0d_strb", idx), {28'b0, dmem_wstrb}, {28'b0, v.exp_strb});
                    check($sformatf("v%0d_wdata", idx), dmem_wdata, v.exp_wdata);
                end
                if (req_cyc - 1 == v.gnt_dly) begin
                    dmem_gnt = 1'b1;
                    gnt_prev = 1'b1;
                end
            end
            if (done) begin
                seen = 1'b1;
                lat  = c;
                check($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, v.exp_err});
                check($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
            end
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check($sformatf("v%0d_done_seen", idx), {31'b0, seen}, 32'd1);
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_req_cycles", idx), req_cyc, v.exp_req);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {31'b0, done}, 32'd0);
        check($sformatf("v%0d_ready_after", idx), {31'b0, ready}, 32'd1);
    endtask

    initial begin
        //           rd    wr    f3      addr          wdata         dly rv    word          exp_addr      strb     exp_wdata     req lat err   exp_rdata
        vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,        0, 1'b1, 32'h80FF_1234, 32'h0000_1000, 4'b0000, 32'h0,        1, 3, 1'b0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0,        0, 1'b1, 32'h80FF_1234, 32'h0000_1000, 4'b0000, 32'h0,        1, 3, 1'b0, 32'h0000_0080};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 3, 1'b0, 32'h0,        32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 4, 5, 1'b0, 32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 1'b1, 32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_3002, 32'h0,        0, 1'b1, 32'h9ABC_0000, 32'h0000_3000, 4'b0000, 32'h0,        1, 3, 1'b0, 32'h0000_9ABC};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_3002, 32'h0,        0, 1'b1, 32'h9ABC_0000, 32'h0000_3000, 4'b0000, 32'h0,        1, 3, 1'b0, 32'hFFFF_9ABC};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 0, 1'b0, 32'h0,        32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 1, 2, 1'b0, 32'hFFFF_9ABC};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF, 1, 1'b0, 32'h0,        32'h0000_0004, 4'b1111, 32'hDEAD_BEEF, 2, 3, 1'b0, 32'hFFFF_9ABC};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0,        2, 1'b1, 32'hCAFE_F00D, 32'h0000_1000, 4'b0000, 32'h0,        3, 5, 1'b0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 1'b1, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 1'b1, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 1'b1, 32'hCAFE_F00D};
        vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0,        0, 1'b0, 32'h0,        32'h0000_4000, 4'b0000, 32'h0,        1, 6, 1'b1, 32'hCAFE_F00D};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h0000_5000, 32'h0,        0, 1'b1, 32'h0000_007F, 32'h0000_5000, 4'b0000, 32'h0,        1, 3, 1'b0, 32'h0000_007F};
        vecs[14] = '{1'b1, 1'b0, 3'b101, 32'h0000_5001, 32'h0,        0, 1'b1, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 1'b1, 32'h0000_007F};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h0000_6003, 32'h0000_1111, 0, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        0, 1, 1'b1, 32'h0000_007F};
        vecs[16] = '{1'b1, 1'b0, 3'b001, 32'h0000_7000, 32'h0,        0, 1'b1, 32'h1234_8001, 32'h0000_7000, 4'b0000, 32'h0,        1, 3, 1'b0, 32'hFFFF_8001};

        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        func3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // req_valid with neither read nor write is not an operation
        @(negedge clk);
        req_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("noop%0d_req", k),   {31'b0, dmem_req}, 32'd0);
            check($sformatf("noop%0d_done", k),  {31'b0, done},     32'd0);
            check($sformatf("noop%0d_ready", k), {31'b0, ready},    32'd1);
        end
        req_valid = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while waiting for a load response; the late rvalid must be dropped
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        func3 = 3'b010; addr = 32'h0000_8000;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_req", {31'b0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rstmid_in_wait_req", {31'b0, dmem_req}, 32'd0);
        check("rstmid_in_wait_ready", {31'b0, ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1122_3344;
        check_reset_values("rstmid");
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check_reset_values("rstmid_after_rv");
        @(negedge clk);
        check("rstmid_late_done", {31'b0, done}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
